// File: rtl/instr_encoder_pkg.sv
// ============================================================================
//  enc_pkg
//  Shared MIPS encodings for the instruction encoder and the core decoder:
//  op-class enum, opcode/funct constants, field positions, packing helpers.
//  Optional feature macro: INSTR_ENCODER_LI_EN (adds the LI2 FSM state).
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package enc_pkg;

  // Symbolic operation classes accepted on the request channel
  typedef enum logic [3:0] {
    OP_ADDU  = 4'd0,
    OP_SUBU  = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_SLTU  = 4'd4,
    OP_LW    = 4'd5,
    OP_SW    = 4'd6,
    OP_BEQ   = 4'd7,
    OP_ADDIU = 4'd8,
    OP_J     = 4'd9,
    OP_LUI   = 4'd10,
    OP_ORI   = 4'd11,
    OP_BLTZ  = 4'd12,
    OP_LI    = 4'd13
  } op_class_e;

  // Primary opcodes
  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_REGIMM  = 6'b000001;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_ADDIU   = 6'b001001;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] OPC_LW      = 6'b100011;
  localparam logic [5:0] OPC_SW      = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // Field LSB positions inside the 32-bit word
  localparam int OPC_POS    = 26;
  localparam int RS_POS     = 21;
  localparam int RT_POS     = 16;
  localparam int RD_POS     = 11;
  localparam int SHAMT_POS  = 6;
  localparam int FUNCT_POS  = 0;
  localparam int IMM_POS    = 0;
  localparam int TARGET_POS = 0;

  // Encoder FSM states; LI2 only exists when the LI pseudo-op is built in
`ifdef INSTR_ENCODER_LI_EN
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LI2  = 1'b1
  } state_e;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0
  } state_e;
`endif

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    logic [31:0] w;
    w = '0;
    w[OPC_POS +: 6]   = OPC_SPECIAL;
    w[RS_POS +: 5]    = rs;
    w[RT_POS +: 5]    = rt;
    w[RD_POS +: 5]    = rd;
    w[SHAMT_POS +: 5] = 5'd0;
    w[FUNCT_POS +: 6] = funct;
    return w;
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    w[OPC_POS +: 6]  = opc;
    w[RS_POS +: 5]   = rs;
    w[RT_POS +: 5]   = rt;
    w[IMM_POS +: 16] = imm;
    return w;
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] opc, input logic [25:0] target);
    logic [31:0] w;
    w = '0;
    w[OPC_POS +: 6]     = opc;
    w[TARGET_POS +: 26] = target;
    return w;
  endfunction

  // Classes that map to exactly one word (everything below LI)
  function automatic logic is_single(input logic [3:0] op);
    return (op <= OP_BLTZ);
  endfunction

  // Single-word encodings; LUI forces rs=0, BLTZ forces rt=0
  function automatic logic [31:0] encode_single(input logic [3:0] op, input logic [4:0] rs,
                                                input logic [4:0] rt, input logic [4:0] rd,
                                                input logic [31:0] imm);
    logic [31:0] w;
    case (op)
      OP_ADDU:  w = enc_r(rs, rt, rd, FN_ADDU);
      OP_SUBU:  w = enc_r(rs, rt, rd, FN_SUBU);
      OP_AND:   w = enc_r(rs, rt, rd, FN_AND);
      OP_OR:    w = enc_r(rs, rt, rd, FN_OR);
      OP_SLTU:  w = enc_r(rs, rt, rd, FN_SLTU);
      OP_LW:    w = enc_i(OPC_LW, rs, rt, imm[15:0]);
      OP_SW:    w = enc_i(OPC_SW, rs, rt, imm[15:0]);
      OP_BEQ:   w = enc_i(OPC_BEQ, rs, rt, imm[15:0]);
      OP_ADDIU: w = enc_i(OPC_ADDIU, rs, rt, imm[15:0]);
      OP_J:     w = enc_j(OPC_J, imm[25:0]);
      OP_LUI:   w = enc_i(OPC_LUI, 5'd0, rt, imm[15:0]);
      OP_ORI:   w = enc_i(OPC_ORI, rs, rt, imm[15:0]);
      OP_BLTZ:  w = enc_i(OPC_REGIMM, rs, 5'd0, imm[15:0]);
      default:  w = '0;
    endcase
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_encoder_if.sv
// ============================================================================
//  instr_encoder_if
//  Request channel (symbolic instruction in) and word channel (encoded word
//  plus byte address out), both valid/ready.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  // Producer of requests / consumer of words
  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  // The encoder itself
  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

`default_nettype wire

// File: rtl/instr_encoder_fifo.sv
// ============================================================================
//  enc_fifo
//  Synchronous FIFO with fall-through head, DEPTH entries (power of two, >=2)
//  of WIDTH bits. Storage resets to RESET_WORD so the head has a defined
//  value while empty.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module enc_fifo #(
  parameter int                 DEPTH      = 2,
  parameter int                 WIDTH      = 64,
  parameter logic [WIDTH-1:0]   RESET_WORD = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]     ONE_COUNT  = (AW+1)'(1);
  localparam logic [AW-1:0]   ONE_PTR    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage, pointers and occupancy; a push and a pop may share a cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_WORD;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + ONE_PTR;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ONE_PTR;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
//  instr_encoder
//  Packs symbolic instruction requests into 32-bit MIPS words, tags each with
//  its byte address and queues them on a buffered valid/ready output.
//  Optional feature macro: INSTR_ENCODER_LI_EN (LI pseudo-op -> LUI + ORI).
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module instr_encoder
  import enc_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  instr_encoder_if.slave    bus,
  output logic              err_illegal,
  input  logic              clear_err
);

  state_e      state;
  state_e      next_state;
  logic        run_en;
  logic        ready;
  logic        push;
  logic [31:0] push_word;
  logic [31:0] addr_cnt;
  logic        err_set;
  logic        fifo_full;
  logic        fifo_empty;
  logic [63:0] head;

`ifdef INSTR_ENCODER_LI_EN
  logic [4:0]  li_rt;
  logic [15:0] li_lo;
  logic        li_load;
`else
  // Upper immediate bits only matter for the LI pseudo-op
  logic        unused_imm_hi;
  assign unused_imm_hi = ^bus.in_imm[31:26];
`endif

  enc_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .WIDTH      (64),
    .RESET_WORD ({32'h0000_0000, START_ADDR})
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({push_word, addr_cnt}),
    .pop       (bus.out_ready),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.in_ready  = ready;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_instr = head[63:32];
  assign bus.out_addr  = head[31:0];

  // Keeps in_ready low while reset is held, registered so it never follows the pin combinationally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_en <= 1'b0;
    else        run_en <= 1'b1;
  end

  // Byte address for the next pushed word; wraps silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    addr_cnt <= START_ADDR;
    else if (push) addr_cnt <= addr_cnt + 32'd4;
  end

  // Sticky illegal-request flag; a new illegal request beats clear_err
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         err_illegal <= 1'b0;
    else if (err_set)   err_illegal <= 1'b1;
    else if (clear_err) err_illegal <= 1'b0;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

`ifdef INSTR_ENCODER_LI_EN
  // Operands of an accepted LI, needed for the ORI half
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      li_rt <= 5'd0;
      li_lo <= 16'd0;
    end else if (li_load) begin
      li_rt <= bus.in_rt;
      li_lo <= bus.in_imm[15:0];
    end
  end
`endif

  // Next state, handshake and word selection; in_ready never depends on out_ready
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    push       = 1'b0;
    push_word  = '0;
    err_set    = 1'b0;
`ifdef INSTR_ENCODER_LI_EN
    li_load    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        ready = run_en && !fifo_full;
        if (bus.in_valid && ready) begin
          if (is_single(bus.in_op)) begin
            push      = 1'b1;
            push_word = encode_single(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm);
`ifdef INSTR_ENCODER_LI_EN
          end else if (bus.in_op == OP_LI) begin
            push       = 1'b1;
            push_word  = enc_i(OPC_LUI, 5'd0, bus.in_rt, bus.in_imm[31:16]);
            li_load    = 1'b1;
            next_state = ST_LI2;
`endif
          end else begin
            err_set = 1'b1;
          end
        end
      end
`ifdef INSTR_ENCODER_LI_EN
      ST_LI2: begin
        if (!fifo_full) begin
          push       = 1'b1;
          push_word  = enc_i(OPC_ORI, li_rt, li_rt, li_lo);
          next_state = ST_IDLE;
        end
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
//  tb_instr_encoder
//  Directed, self-checking bench for instr_encoder (default parameters).
//  Honours INSTR_ENCODER_LI_EN the same way the design does.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clear_err = 1'b0;
  logic err_illegal;
  int   n_cmp = 0;
  int   n_bad = 0;

  instr_encoder_if bus();

  always #5 clk = ~clk;

  instr_encoder #(
    .START_ADDR (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .err_illegal (err_illegal),
    .clear_err   (clear_err)
  );

  // Directed table for single-word classes, sent back to back
  logic [3:0]  mx_op  [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11};
  logic [4:0]  mx_rs  [9] = '{5'd4, 5'd7, 5'd31, 5'd1, 5'd29, 5'd1, 5'd3, 5'd7, 5'd2};
  logic [4:0]  mx_rt  [9] = '{5'd5, 5'd8, 5'd31, 5'd2, 5'd31, 5'd2, 5'd4, 5'd3, 5'd4};
  logic [4:0]  mx_rd  [9] = '{5'd6, 5'd9, 5'd31, 5'd3, 5'd17, 5'd17, 5'd17, 5'd17, 5'd17};
  logic [31:0] mx_imm [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0008, 32'hFFFF_FFFD,
                              32'hFC00_0040, 32'hABCD_1234, 32'h0000_00FF};
  logic [31:0] mx_exp [9] = '{32'h0085_3023, 32'h00E8_4824, 32'h03FF_F825, 32'h0022_182B,
                              32'hAFBF_0008, 32'h1022_FFFD, 32'h0800_0040, 32'h3C03_1234,
                              32'h3444_00FF};

  task automatic idle_bus();
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'd0;
    bus.in_rs     = 5'd0;
    bus.in_rt     = 5'd0;
    bus.in_rd     = 5'd0;
    bus.in_imm    = 32'd0;
    bus.out_ready = 1'b1;
  endtask

  task automatic set_req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] imm);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
    bus.in_imm   = imm;
  endtask

  // Ends at a falling edge one full cycle after reset release
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_err = 1'b0;
    idle_bus();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_bus();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_instr !== 32'h0) begin n_bad++; $display("FAIL rst_out_instr: got %h want 00000000", bus.out_instr); end
    n_cmp++; if (bus.out_addr !== 32'h0) begin n_bad++; $display("FAIL rst_out_addr: got %h want 00000000", bus.out_addr); end
    n_cmp++; if (err_illegal !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_illegal); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_release_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_addu();
    do_reset();
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL addu_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_instr !== 32'h0022_1821) begin n_bad++; $display("FAIL addu_instr: got %h want 00221821", bus.out_instr); end
    n_cmp++; if (bus.out_addr !== 32'h0) begin n_bad++; $display("FAIL addu_addr: got %h want 00000000", bus.out_addr); end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL addu_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_lw_bltz();
    do_reset();
    set_req(4'd5, 5'd29, 5'd8, 5'd0, 32'h0000_0004);
    @(negedge clk);
    n_cmp++; if (bus.out_instr !== 32'h8FA8_0004 || bus.out_addr !== 32'h0) begin n_bad++; $display("FAIL lw_word: got %h@%h want 8fa80004@00000000", bus.out_instr, bus.out_addr); end
    set_req(4'd12, 5'd4, 5'd7, 5'd0, 32'h0000_FFFE);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h0480_FFFE || bus.out_addr !== 32'h4) begin n_bad++; $display("FAIL bltz_word: got v=%b %h@%h want v=1 0480fffe@00000004", bus.out_valid, bus.out_instr, bus.out_addr); end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bltz_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_mixed();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_req(mx_op[i], mx_rs[i], mx_rt[i], mx_rd[i], mx_imm[i]);
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== mx_exp[i] || bus.out_addr !== 32'(4 * i)) begin
        n_bad++;
        $display("FAIL mixed_%0d: got v=%b %h@%h want v=1 %h@%h", i, bus.out_valid, bus.out_instr, bus.out_addr, mx_exp[i], 32'(4 * i));
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mixed_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_li();
    do_reset();
    set_req(4'd13, 5'd0, 5'd9, 5'd0, 32'h1234_5678);
    @(negedge clk);
    bus.in_valid = 1'b0;
`ifdef INSTR_ENCODER_LI_EN
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL li_ready_low: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_instr !== 32'h3C09_1234 || bus.out_addr !== 32'h0) begin n_bad++; $display("FAIL li_lui: got %h@%h want 3c091234@00000000", bus.out_instr, bus.out_addr); end
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL li_ready_back: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h3529_5678 || bus.out_addr !== 32'h4) begin n_bad++; $display("FAIL li_ori: got v=%b %h@%h want v=1 35295678@00000004", bus.out_valid, bus.out_instr, bus.out_addr); end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL li_drain: got %b want 0", bus.out_valid); end
`else
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL li_off_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (err_illegal !== 1'b1) begin n_bad++; $display("FAIL li_off_err: got %b want 1", err_illegal); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL li_off_ready: got %b want 1", bus.in_ready); end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.out_ready = 1'b0;
    set_req(4'd8, 5'd1, 5'd2, 5'd0, 32'h0000_0010);
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_one: got %b want 1", bus.in_ready); end
    set_req(4'd8, 5'd3, 5'd4, 5'd0, 32'h0000_0020);
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h2422_0010 || bus.out_addr !== 32'h0) begin n_bad++; $display("FAIL bp_head1: got v=%b %h@%h want v=1 24220010@00000000", bus.out_valid, bus.out_instr, bus.out_addr); end
    set_req(4'd8, 5'd5, 5'd6, 5'd0, 32'h0000_FFFF);
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_instr !== 32'h2422_0010 || bus.out_addr !== 32'h0) begin n_bad++; $display("FAIL bp_stable: got %h@%h want 24220010@00000000", bus.out_instr, bus.out_addr); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_instr !== 32'h2464_0020 || bus.out_addr !== 32'h4) begin n_bad++; $display("FAIL bp_head2: got %h@%h want 24640020@00000004", bus.out_instr, bus.out_addr); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_free: got %b want 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h24A6_FFFF || bus.out_addr !== 32'h8) begin n_bad++; $display("FAIL bp_head3: got v=%b %h@%h want v=1 24a6ffff@00000008", bus.out_valid, bus.out_instr, bus.out_addr); end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_illegal();
    do_reset();
    set_req(4'd14, 5'd1, 5'd2, 5'd3, 32'd0);
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL ill_no_word: got %b want 0", bus.out_valid); end
    n_cmp++; if (err_illegal !== 1'b1) begin n_bad++; $display("FAIL ill_err_set: got %b want 1", err_illegal); end
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h0022_1821 || bus.out_addr !== 32'h0) begin n_bad++; $display("FAIL ill_next_addr: got v=%b %h@%h want v=1 00221821@00000000", bus.out_valid, bus.out_instr, bus.out_addr); end
    n_cmp++; if (err_illegal !== 1'b1) begin n_bad++; $display("FAIL ill_err_sticky: got %b want 1", err_illegal); end
    set_req(4'd15, 5'd0, 5'd0, 5'd0, 32'd0);
    clear_err = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++; if (err_illegal !== 1'b1) begin n_bad++; $display("FAIL ill_set_wins: got %b want 1", err_illegal); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL ill15_no_word: got %b want 0", bus.out_valid); end
    @(negedge clk);
    clear_err = 1'b0;
    n_cmp++; if (err_illegal !== 1'b0) begin n_bad++; $display("FAIL ill_cleared: got %b want 0", err_illegal); end
  endtask

  task automatic test_reset_mid_li();
    do_reset();
    bus.out_ready = 1'b0;
`ifdef INSTR_ENCODER_LI_EN
    set_req(4'd13, 5'd0, 5'd9, 5'd0, 32'h1234_5678);
`else
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_instr !== 32'h0 || bus.out_addr !== 32'h0) begin n_bad++; $display("FAIL mid_rst_word: got %h@%h want 00000000@00000000", bus.out_instr, bus.out_addr); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 0", bus.in_ready); end
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_no_ori_%0d: got %b want 0", i, bus.out_valid); end
    end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready_back: got %b want 1", bus.in_ready); end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_bltz();
    test_mixed();
    test_li();
    test_back_to_back();
    test_illegal();
    test_reset_mid_li();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
